// File: rtl/ram_autoconfig_multi.sv
// ram_autoconfig_multi: presents N_BOARDS Zorro II autoconfig memory boards in
// sequence on one card. It has a synchronous bus-cycle FSM with a registered
// DTACK, per-board RAM chip enables and a control/status register page.
// Optional build macro: MAPROM_EN (map-ROM overlay on F80000-FFFFFF).
module ram_autoconfig_multi #(
    parameter int unsigned N_BOARDS     = 2,
    parameter int unsigned SIZE_LOG2    = 21,
    parameter logic [7:0]  PRODUCT      = 8'h00,
    parameter logic [15:0] MANUFACTURER = 16'h5000,
    parameter logic [11:0] CTRL_BASE    = 12'hE9C
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                _AS,
    input  logic                _UDS,
    input  logic                RW,
    input  logic [11:0]         AH,
    input  logic [5:0]          AL,
    input  logic [3:0]          D_i,
    input  logic                _configin,
    output logic                _configout,
    output logic [3:0]          D_o,
    output logic                data_oe,
    output logic                DTACK,
    output logic                OVR,
    output logic [N_BOARDS-1:0] ram_ce
);

    localparam int unsigned      CFG_W     = $clog2(N_BOARDS + 1);
    localparam logic [CFG_W-1:0] DONE_IDX  = CFG_W'(N_BOARDS);
    localparam logic [CFG_W-1:0] LAST_IDX  = CFG_W'(N_BOARDS - 1);
    localparam logic [11:0]      RAM_MASK  = 12'(12'hFFF << (SIZE_LOG2 - 12));
    localparam logic [2:0]       SIZE_CODE = 3'(SIZE_LOG2 - 15);

    // Autoconfig register offsets as seen on AL (address bits 6:1)
    localparam logic [5:0] AL_BASE_HI = 6'h24;
    localparam logic [5:0] AL_BASE_LO = 6'h25;
    localparam logic [5:0] AL_SHUTUP  = 6'h26;

    typedef enum logic [1:0] {IDLE, DECODE, ACK, WAIT_END} state_t;

    state_t              state;
    logic                as_meta, as_s, as_prev;
    logic                uds_meta, uds_s;
    logic [CFG_W-1:0]    cfg_idx;
    logic [7:0]          base [N_BOARDS];
    logic [N_BOARDS-1:0] configured;
    logic [N_BOARDS-1:0] shutup;
    logic                write_done;
    logic                cyc_cfg, cyc_ctrl;

    logic                chain_done, chained;
    logic                autoconfig_hit, ctrl_hit, ram_hit;
    logic                maprom_rd;
    logic                wr_stb, acfg_wr;
    logic [3:0]          rd_nibble;
    logic [N_BOARDS-1:0] ram_raw, ram_pri;
    logic                taken;

    assign chain_done     = (cfg_idx == DONE_IDX);
    assign chained        = (cfg_idx < LAST_IDX);
    assign autoconfig_hit = (AH[11:4] == 8'hE8) && !_configin && !chain_done;
    assign ctrl_hit       = (AH == CTRL_BASE);
    assign ram_hit        = |ram_ce;
    assign _configout     = !chain_done;
    assign OVR            = !RST && !_AS && (ctrl_hit || maprom_rd);

    // One write commit per bus cycle: first ACK clock with data strobe low
    assign wr_stb  = (state == ACK) && !as_s && !RW && !uds_s && !write_done;
    assign acfg_wr = wr_stb && cyc_cfg;

`ifdef MAPROM_EN
    logic       maprom_on = 1'b0;
    logic [1:0] arm;
    logic       rom_range;
    logic       ctrl_wr;

    assign rom_range = (AH[11:7] == 5'b11111);
    assign maprom_rd = maprom_on && RW && rom_range;
    assign ctrl_wr   = wr_stb && cyc_ctrl;

    // Arm counter: counts ROM-range writes while the overlay is off, saturating at 3
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            arm <= 2'd0;
        end else if (ctrl_wr && !D_i[3]) begin
            arm <= 2'd0;
        end else if (state == DECODE && !RW && rom_range && !maprom_on && arm != 2'd3) begin
            arm <= arm + 2'd1;
        end
    end

    // Overlay enable survives RST; only power-up init or a control write changes it
    always_ff @(posedge CLK) begin
        if (ctrl_wr) begin
            maprom_on <= D_i[3] ? (maprom_on || arm == 2'd3) : 1'b0;
        end
    end
`else
    logic maprom_on;
    assign maprom_on = 1'b0;
    assign maprom_rd = 1'b0;
`endif

    // Strobe synchronisers and previous-_AS sample for falling-edge detection
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            as_meta  <= 1'b1;
            as_s     <= 1'b1;
            as_prev  <= 1'b1;
            uds_meta <= 1'b1;
            uds_s    <= 1'b1;
        end else begin
            as_meta  <= _AS;
            as_s     <= as_meta;
            as_prev  <= as_s;
            uds_meta <= _UDS;
            uds_s    <= uds_meta;
        end
    end

    // RAM decode from the live address; the lowest configured board wins on overlap
    always_comb begin
        ram_raw = '0;
        ram_pri = '0;
        taken   = 1'b0;
        ram_ce  = '0;
        for (int k = 0; k < N_BOARDS; k++) begin
            ram_raw[k] = configured[k] && !shutup[k] &&
                         (((AH ^ {base[k], 4'h0}) & RAM_MASK) == 12'h000);
        end
        for (int k = 0; k < N_BOARDS; k++) begin
            if (ram_raw[k] && !taken) begin
                ram_pri[k] = 1'b1;
                taken      = 1'b1;
            end
        end
        if (!RST && !_AS) begin
            ram_ce = maprom_rd ? N_BOARDS'(1) : ram_pri;
        end
    end

    // Read data for autoconfig and control accesses
    always_comb begin
        rd_nibble = 4'hF;
        if (ctrl_hit) begin
            rd_nibble = {maprom_on, chain_done, |shutup, 1'b0};
        end else begin
            case (AL)
                6'h00:        rd_nibble = 4'hE;
                6'h01:        rd_nibble = {chained, SIZE_CODE};
                6'h02:        rd_nibble = ~PRODUCT[7:4];
                6'h03:        rd_nibble = ~PRODUCT[3:0];
                6'h04:        rd_nibble = 4'h3;
                6'h08:        rd_nibble = ~MANUFACTURER[15:12];
                6'h09:        rd_nibble = ~MANUFACTURER[11:8];
                6'h0A:        rd_nibble = ~MANUFACTURER[7:4];
                6'h0B:        rd_nibble = ~MANUFACTURER[3:0];
                6'h20, 6'h21: rd_nibble = 4'h0;
                default:      rd_nibble = 4'hF;
            endcase
        end
    end

    // Bus-cycle FSM with registered DTACK/data outputs and autoconfig state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            DTACK      <= 1'b0;
            data_oe    <= 1'b0;
            D_o        <= 4'h0;
            write_done <= 1'b0;
            cyc_cfg    <= 1'b0;
            cyc_ctrl   <= 1'b0;
            cfg_idx    <= '0;
            configured <= '0;
            shutup     <= '0;
            for (int k = 0; k < N_BOARDS; k++) begin
                base[k] <= 8'h00;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (as_prev && !as_s) begin
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (autoconfig_hit || ctrl_hit || ram_hit) begin
                        state      <= ACK;
                        DTACK      <= 1'b1;
                        data_oe    <= RW && (autoconfig_hit || ctrl_hit);
                        D_o        <= (RW && (autoconfig_hit || ctrl_hit)) ? rd_nibble : 4'h0;
                        cyc_cfg    <= autoconfig_hit;
                        cyc_ctrl   <= ctrl_hit;
                        write_done <= 1'b0;
                    end else begin
                        state <= WAIT_END;
                    end
                end
                ACK: begin
                    if (as_s) begin
                        state   <= IDLE;
                        DTACK   <= 1'b0;
                        data_oe <= 1'b0;
                        D_o     <= 4'h0;
                    end else if (wr_stb) begin
                        write_done <= 1'b1;
                    end
                    if (acfg_wr) begin
                        for (int k = 0; k < N_BOARDS; k++) begin
                            if (cfg_idx == CFG_W'(k)) begin
                                case (AL)
                                    AL_BASE_LO: base[k][3:0] <= D_i;
                                    AL_BASE_HI: begin
                                        base[k][7:4]  <= D_i;
                                        configured[k] <= 1'b1;
                                    end
                                    AL_SHUTUP:  shutup[k] <= 1'b1;
                                    default:    ;
                                endcase
                            end
                        end
                        if ((AL == AL_BASE_HI || AL == AL_SHUTUP) && !chain_done) begin
                            cfg_idx <= cfg_idx + CFG_W'(1);
                        end
                    end
                end
                WAIT_END: begin
                    if (as_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_autoconfig_multi.sv
// Self-checking bench for ram_autoconfig_multi (default build, 2 boards of 2 MB).
module tb_ram_autoconfig_multi;

    localparam int unsigned NB    = 2;
    localparam int unsigned SL    = 21;
    localparam logic [7:0]  PROD  = 8'h00;
    localparam logic [15:0] MANU  = 16'h5000;
    localparam logic [11:0] CBASE = 12'hE9C;

    logic          CLK = 1'b0;
    logic          RST, _AS, _UDS, RW, _configin;
    logic [11:0]   AH;
    logic [5:0]    AL;
    logic [3:0]    D_i;
    logic          _configout, data_oe, DTACK, OVR;
    logic [3:0]    D_o;
    logic [NB-1:0] ram_ce;

    ram_autoconfig_multi #(
        .N_BOARDS(NB), .SIZE_LOG2(SL), .PRODUCT(PROD),
        .MANUFACTURER(MANU), .CTRL_BASE(CBASE)
    ) dut (
        .CLK(CLK), .RST(RST), ._AS(_AS), ._UDS(_UDS), .RW(RW),
        .AH(AH), .AL(AL), .D_i(D_i), ._configin(_configin),
        ._configout(_configout), .D_o(D_o), .data_oe(data_oe),
        .DTACK(DTACK), .OVR(OVR), .ram_ce(ram_ce)
    );

    always #5 CLK = ~CLK;

    int tests  = 0;
    int errors = 0;

    // Reference model of the card's configuration state
    logic [7:0]    base_m [NB];
    logic [NB-1:0] cfg_m, shut_m;
    int            idx_m;

    // Results of the last bus cycle
    logic          ack, oe, ovr;
    logic [3:0]    rd;
    logic [NB-1:0] ce;
    int            lat;

    logic [23:0]   a;
    logic [7:0]    b0, b1;
    int            off, n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        idx_m  = 0;
        cfg_m  = '0;
        shut_m = '0;
        for (int k = 0; k < NB; k++) base_m[k] = 8'h00;
    endtask

    function automatic logic [3:0] exp_acfg(input int o);
        int sz;
        logic [3:0] v;
        sz = (SL == 23) ? 0 : int'(SL) - 15;
        case (o)
            'h00: v = 4'hE;
            'h02: v = {(idx_m < int'(NB) - 1), 3'(sz)};
            'h04: v = ~PROD[7:4];
            'h06: v = ~PROD[3:0];
            'h08: v = 4'h3;
            'h10: v = ~MANU[15:12];
            'h12: v = ~MANU[11:8];
            'h14: v = ~MANU[7:4];
            'h16: v = ~MANU[3:0];
            'h40, 'h42: v = 4'h0;
            default: v = 4'hF;
        endcase
        return v;
    endfunction

    // A board answers when the address bits above its size equal its base bits
    function automatic logic [NB-1:0] exp_ce(input logic [23:0] x);
        for (int k = 0; k < NB; k++) begin
            if (cfg_m[k] && !shut_m[k] && int'(x >> SL) == int'(base_m[k] >> (SL - 16)))
                return NB'(1) << k;
        end
        return '0;
    endfunction

    // One complete 68000 bus cycle, including a repeated data strobe while held
    task automatic bus(input logic [23:0] ad, input logic rw, input logic [3:0] wd);
        int gone;
        @(negedge CLK);
        AH = ad[23:12]; AL = ad[6:1]; RW = rw; D_i = wd;
        _AS = 1'b0; _UDS = 1'b0;
        #1;
        ce = ram_ce; ovr = OVR;
        ack = 1'b0; lat = 0; oe = 1'b0; rd = 4'h0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge CLK);
            if (DTACK) begin
                ack = 1'b1; lat = i; oe = data_oe; rd = D_o;
                break;
            end
        end
        @(negedge CLK); _UDS = 1'b1;
        repeat (3) @(negedge CLK);
        _UDS = 1'b0;
        repeat (3) @(negedge CLK);
        _AS = 1'b1; _UDS = 1'b1;
        if (ack) begin
            gone = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge CLK);
                if (!DTACK) begin gone = 1; break; end
            end
            check("dtack_release", gone, 1);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic cfg_write(input logic [7:0] o, input logic [3:0] d);
        int k;
        k = idx_m;
        bus(24'hE80000 | 24'(o), 1'b0, d);
        check("cfg_wr_ack", ack, 1);
        if (o == 8'h4A) base_m[k][3:0] = d;
        else if (o == 8'h48) begin base_m[k][7:4] = d; cfg_m[k] = 1'b1; idx_m++; end
        else if (o == 8'h4C) begin shut_m[k] = 1'b1; idx_m++; end
    endtask

    task automatic pulse_reset();
        @(negedge CLK); RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
    endtask

    task automatic ram_probe(input logic [23:0] x);
        logic [NB-1:0] e;
        e = exp_ce(x);
        bus(x, 1'b1, 4'h0);
        check("ram_ce", ce, e);
        check("ram_ack", ack, (|e) || (x[23:12] == CBASE));
        if (|e && x[23:12] != CBASE) check("ram_oe", oe, 0);
    endtask

    initial begin
        RST = 1'b1; _AS = 1'b1; _UDS = 1'b1; RW = 1'b1;
        AH = '0; AL = '0; D_i = '0; _configin = 1'b0;
        model_reset();
        #1;
        check("rst_dtack", DTACK, 0);
        check("rst_oe", data_oe, 0);
        check("rst_do", D_o, 0);
        check("rst_ovr", OVR, 0);
        check("rst_ce", ram_ce, 0);
        check("rst_cfgout", _configout, 1);
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        // Identification reads and DTACK latency
        bus(24'hE80000, 1'b1, 4'h0);
        check("id0_ack", ack, 1);
        check("id0_lat", lat, 4);
        check("id0_oe", oe, 1);
        check("id0_data", rd, exp_acfg('h00));
        bus(24'hE80002, 1'b1, 4'h0);
        check("id2_data", rd, exp_acfg('h02));
        check("id2_lat", lat, 4);
        for (int i = 0; i < 6; i++) begin
            off = int'($urandom_range(0, 63)) * 2;
            bus(24'hE80000 | 24'(off), 1'b1, 4'h0);
            check("idr_ack", ack, 1);
            check("idr_data", rd, exp_acfg(off));
        end

        // Board 0 at 0x200000; next board then reports not chained
        cfg_write(8'h4A, 4'h0);
        cfg_write(8'h48, 4'h2);
        bus(24'hE80002, 1'b1, 4'h0);
        check("id2_after", rd, exp_acfg('h02));
        check("id2_after_val", rd, 4'h6);
        ram_probe(24'h200000);
        ram_probe(24'h400000);
        for (int i = 0; i < 6; i++) ram_probe(24'($urandom_range(0, 32'hBFFFFF)));

        // Board 1 shuts up: chain done, control status reflects it
        cfg_write(8'h4C, 4'h0);
        check("shut_cfgout", _configout, 0);
        bus(24'hE80000, 1'b1, 4'h0);
        check("done_ack", ack, 0);
        check("done_oe", oe, 0);
        bus({CBASE, 12'h000}, 1'b1, 4'h0);
        check("ctrl_ack", ack, 1);
        check("ctrl_ovr", ovr, 1);
        check("ctrl_data", rd, 4'h6);
        for (int i = 0; i < 6; i++) ram_probe(24'($urandom_range(0, 32'h9FFFFF)));

        // Reset in the middle of an acknowledged RAM cycle
        @(negedge CLK);
        AH = 12'h200; AL = '0; RW = 1'b1; _AS = 1'b0; _UDS = 1'b0;
        n = 0;
        while (!DTACK && n < 10) begin @(negedge CLK); n++; end
        check("mid_ack", DTACK, 1);
        check("mid_ce", ram_ce, exp_ce(24'h200000));
        RST = 1'b1;
        #1;
        check("mid_rst_dtack", DTACK, 0);
        check("mid_rst_cfgout", _configout, 1);
        check("mid_rst_ce", ram_ce, 0);
        check("mid_rst_oe", data_oe, 0);
        _AS = 1'b1; _UDS = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);

        // Chain gating by _configin
        _configin = 1'b1;
        bus(24'hE80000, 1'b1, 4'h0);
        check("gate_ack", ack, 0);
        check("gate_oe", oe, 0);
        _configin = 1'b0;

        // Map-ROM sequence: overlay absent in this build
        for (int i = 0; i < 3; i++) begin
            bus(24'hF80000, 1'b0, 4'h0);
            check("rom_wr_ack", ack, 0);
        end
        bus({CBASE, 12'h000}, 1'b0, 4'h8);
        check("ctrl_wr_ack", ack, 1);
        bus(24'hFC0000, 1'b1, 4'h0);
        check("rom_rd_ce", ce, 0);
        check("rom_rd_ovr", ovr, 0);
        check("rom_rd_ack", ack, 0);
        bus({CBASE, 12'h000}, 1'b1, 4'h0);
        check("ctrl_rd_clear", rd, 4'h0);

        // Two randomly based boards, second round forced to overlap
        for (int r = 0; r < 2; r++) begin
            pulse_reset();
            b0 = 8'($urandom_range(0, 32'h9F));
            b1 = (r == 1) ? b0 : 8'($urandom_range(0, 32'h9F));
            cfg_write(8'h4A, b0[3:0]);
            cfg_write(8'h48, b0[7:4]);
            cfg_write(8'h4A, b1[3:0]);
            cfg_write(8'h48, b1[7:4]);
            check("two_cfgout", _configout, 0);
            ram_probe({b0, 16'($urandom)});
            ram_probe({b1, 16'($urandom)});
            for (int i = 0; i < 3; i++) ram_probe(24'($urandom_range(0, 32'hBFFFFF)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
